// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the ALU has priority, load returns are buffered
// in an in-order FIFO, and a starvation counter forces the FIFO through.
module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [3:0]       alu_dst,
  input  logic [15:0]      alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [3:0]       ld_dst,
  input  logic [15:0]      ld_data,
  output logic [3:0]       DstReg,
  output logic [15:0]      DstData,
  output logic             WriteReg,
  output logic             alu_stall,
  output logic [15:0]      pending_mask,
  output logic [CNT_W-1:0] fifo_count,
  output logic             proto_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [3:0]       fifo_dst_q  [FIFO_DEPTH];
  logic [15:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             proto_err_q, proto_err_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       dst_q, dst_d;
  logic [15:0]      data_q, data_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [PTR_W-1:0] offs;
  logic [15:0]      pend;

  assign fifo_empty = (count_q == '0);
  assign ld_ready   = !rst && (count_q < CNT_W'(FIFO_DEPTH));
  assign alu_stall  = (count_q == CNT_W'(FIFO_DEPTH)) || (starve_q >= SC_W'(STARVE_LIMIT));
  assign push       = ld_valid && ld_ready;
  assign pop        = !alu_valid && !fifo_empty;

  // Winner selection, FIFO bookkeeping and starvation tracking
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    proto_err_d = proto_err_q;
    wr_en_d     = 1'b0;
    dst_d       = dst_q;
    data_d      = data_q;

    if (alu_valid) begin
      wr_en_d = (alu_dst != 4'd0);
      dst_d   = alu_dst;
      data_d  = alu_data;
    end else if (pop) begin
      wr_en_d  = (fifo_dst_q[rd_ptr_q] != 4'd0);
      dst_d    = fifo_dst_q[rd_ptr_q];
      data_d   = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (alu_valid && (starve_q < SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end

    if (alu_valid && alu_stall) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      dst_q       <= '0;
      data_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
      wr_en_q     <= wr_en_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
    end
  end

  // Payload storage; validity is tracked solely by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dst_q[wr_ptr_q]  <= ld_dst;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  // Slot i is live when its distance from the read pointer is below the occupancy
  always_comb begin
    pend = '0;
    offs = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(offs) < count_q) pend[fifo_dst_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign pending_mask = pend;
  assign fifo_count   = count_q;
  assign proto_err    = proto_err_q;
  assign WriteReg     = wr_en_q;
  assign DstReg       = dst_q;
  assign DstData      = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: ALU/load writes, starvation, full FIFO, r0, async reset.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_dst;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_dst;
  logic [15:0] ld_data;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        WriteReg;
  logic        alu_stall;
  logic [15:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        proto_err;

  int passed = 0;
  int total  = 0;

  wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .DstReg(DstReg), .DstData(DstData), .WriteReg(WriteReg),
    .alu_stall(alu_stall), .pending_mask(pending_mask),
    .fifo_count(fifo_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    ld_valid = 1'b0; ld_dst = '0; ld_data = '0;
    #3;
    check("rst_wr",      32'(WriteReg), 32'd0);
    check("rst_cnt",     32'(fifo_count), 32'd0);
    check("rst_ready",   32'(ld_ready), 32'd0);
    check("rst_stall",   32'(alu_stall), 32'd0);
    check("rst_perr",    32'(proto_err), 32'd0);
    check("rst_pend",    32'(pending_mask), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ld_ready), 32'd1);

    // ALU write, latency 1
    alu_valid = 1'b1; alu_dst = 4'd5; alu_data = 16'h1234;
    tick();
    check("alu_wr",   32'(WriteReg), 32'd1);
    check("alu_dst",  32'(DstReg), 32'd5);
    check("alu_data", 32'(DstData), 32'h1234);
    alu_valid = 1'b0;
    tick();
    check("alu_idle_wr", 32'(WriteReg), 32'd0);

    // Load write, latency 2
    ld_valid = 1'b1; ld_dst = 4'd7; ld_data = 16'hBEEF;
    tick();
    check("ld_cnt1",  32'(fifo_count), 32'd1);
    check("ld_pend",  32'(pending_mask), 32'h0080);
    check("ld_nowr",  32'(WriteReg), 32'd0);
    ld_valid = 1'b0;
    tick();
    check("ld_wr",    32'(WriteReg), 32'd1);
    check("ld_dst",   32'(DstReg), 32'd7);
    check("ld_data",  32'(DstData), 32'hBEEF);
    check("ld_pend0", 32'(pending_mask), 32'd0);
    check("ld_cnt0",  32'(fifo_count), 32'd0);

    // Starvation: one load buffered while the ALU keeps winning
    ld_valid = 1'b1; ld_dst = 4'd3; ld_data = 16'h3333;
    alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h0101;
    tick();
    check("stv_cnt",  32'(fifo_count), 32'd1);
    check("stv_alu",  32'(DstReg), 32'd1);
    ld_valid = 1'b0; alu_dst = 4'd2; alu_data = 16'h0202;
    tick();
    check("stv_s1", 32'(alu_stall), 32'd0);
    tick();
    check("stv_s2", 32'(alu_stall), 32'd0);
    tick();
    check("stv_s3", 32'(alu_stall), 32'd1);
    check("stv_dst2", 32'(DstReg), 32'd2);
    alu_valid = 1'b0;
    tick();
    check("stv_pop_wr",   32'(WriteReg), 32'd1);
    check("stv_pop_dst",  32'(DstReg), 32'd3);
    check("stv_pop_data", 32'(DstData), 32'h3333);
    check("stv_release",  32'(alu_stall), 32'd0);
    check("stv_perr",     32'(proto_err), 32'd0);

    // Fill FIFO with ALU busy, then violate the stall
    alu_valid = 1'b1; alu_dst = 4'd4; alu_data = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_dst = 4'(8 + i); ld_data = 16'(16'hA0 + i);
      tick();
    end
    check("full_cnt",   32'(fifo_count), 32'd4);
    check("full_ready", 32'(ld_ready), 32'd0);
    check("full_stall", 32'(alu_stall), 32'd1);
    check("full_pend",  32'(pending_mask), 32'h0F00);
    ld_valid = 1'b0; alu_dst = 4'd6; alu_data = 16'h6666;
    tick();
    check("viol_wr",   32'(WriteReg), 32'd1);
    check("viol_dst",  32'(DstReg), 32'd6);
    check("viol_data", 32'(DstData), 32'h6666);
    check("viol_cnt",  32'(fifo_count), 32'd4);
    check("viol_perr", 32'(proto_err), 32'd1);
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_wr",   32'(WriteReg), 32'd1);
      check("drain_dst",  32'(DstReg), 32'(8 + i));
      check("drain_data", 32'(DstData), 32'(16'hA0 + i));
      check("drain_cnt",  32'(fifo_count), 32'(3 - i));
    end
    check("drain_stall",  32'(alu_stall), 32'd0);
    check("perr_sticky",  32'(proto_err), 32'd1);

    // Register 0 never gets a write enable
    alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 16'hAAAA;
    tick();
    check("r0_alu_wr",   32'(WriteReg), 32'd0);
    check("r0_alu_data", 32'(DstData), 32'hAAAA);
    alu_valid = 1'b0; ld_valid = 1'b1; ld_dst = 4'd0; ld_data = 16'h5555;
    tick();
    check("r0_ld_wr0",  32'(WriteReg), 32'd0);
    check("r0_ld_cnt",  32'(fifo_count), 32'd1);
    check("r0_ld_pend", 32'(pending_mask), 32'd0);
    ld_valid = 1'b0;
    tick();
    check("r0_pop_wr",   32'(WriteReg), 32'd0);
    check("r0_pop_cnt",  32'(fifo_count), 32'd0);
    check("r0_pop_data", 32'(DstData), 32'h5555);

    // Async reset with three entries buffered
    alu_valid = 1'b1; alu_dst = 4'd9; alu_data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_dst = 4'(12 + i); ld_data = 16'(16'hC0 + i);
      tick();
    end
    check("prerst_cnt", 32'(fifo_count), 32'd3);
    check("prerst_wr",  32'(WriteReg), 32'd1);
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_cnt",   32'(fifo_count), 32'd0);
    check("arst_wr",    32'(WriteReg), 32'd0);
    check("arst_pend",  32'(pending_mask), 32'd0);
    check("arst_perr",  32'(proto_err), 32'd0);
    check("arst_ready", 32'(ld_ready), 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_wr",  32'(WriteReg), 32'd0);
      check("post_rst_cnt", 32'(fifo_count), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of buffered load-return entries (power of two, at least 2).
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive ALU-won cycles with a non-empty FIFO before the FIFO is forced through.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU result requests a register write this cycle; no back-pressure.
REQ-006 alu_dst  input  4  ALU destination register.
REQ-007 alu_data  input  16  ALU result.
REQ-008 ld_valid  input  1  load return is offered.
REQ-009 ld_ready  output  1  load return is accepted when ld_valid and ld_ready are both high.
REQ-010 ld_dst  input  4  load destination register.
REQ-011 ld_data  input  16  load data.
REQ-012 DstReg  output  4  register-file write address (registered).
REQ-013 DstData  output  16  register-file write data (registered).
REQ-014 WriteReg  output  1  register-file write enable (registered).
REQ-015 alu_stall  output  1  upstream SHALL NOT assert alu_valid while this is high.
REQ-016 pending_mask  output  16  bit r is high when any FIFO entry targets register r.
REQ-017 fifo_count  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-018 proto_err  output  1  sticky flag, set when alu_valid is seen while alu_stall is high.

Function
REQ-019 Load returns SHALL be pushed into a FIFO_DEPTH-entry FIFO; they are never written directly.
REQ-020 ld_ready SHALL equal (!rst && fifo_count < FIFO_DEPTH), decoded from registered state only, not from this cycle's pop.
REQ-021 The winner each cycle SHALL be chosen as follows:
- alu_valid high: ALU wins.
- else FIFO non-empty: FIFO head is popped.
- else: no winner.
REQ-022 ALU latency SHALL be 1: alu_valid at edge N drives WriteReg, DstReg and DstData with the ALU values after edge N+1.
REQ-023 Load latency SHALL be at least 2: a load accepted at N reaches the FIFO at N+1; if it pops at N+1, the write appears after edge N+2.
REQ-024 The FIFO SHALL pop strictly in order; a push and a pop in the same cycle SHALL both take effect and leave fifo_count unchanged.
REQ-025 WriteReg SHALL be low in any cycle after no winner.
REQ-026 WriteReg SHALL also be low when the winning destination is register 0; the entry is still consumed and DstReg/DstData still update.
REQ-027 Starvation counter:
- increments, saturating at STARVE_LIMIT, each cycle the ALU wins while the FIFO is non-empty;
- clears on any FIFO pop;
- clears whenever the FIFO is empty.
REQ-028 alu_stall SHALL equal (fifo_count == FIFO_DEPTH) || (starve_cnt >= STARVE_LIMIT), decoded from registered state.
REQ-029 If alu_valid is high while alu_stall is high, the ALU SHALL still win, no FIFO pop occurs, and proto_err SHALL set at the next edge, remaining set until reset.
REQ-030 pending_mask SHALL be the OR of one-hot decodes of the destinations of valid FIFO entries, with bit 0 forced low.
- pending_mask is combinational from FIFO state.
- An entry clears from pending_mask the cycle after it pops.
REQ-031 Ordering of writes to the same register from the ALU and a load is upstream's responsibility, using pending_mask; the block SHALL NOT reorder writes.

Reset
REQ-032 While rst is high, all state SHALL be cleared immediately, regardless of clk:
- WriteReg=0, DstReg=0, DstData=0;
- FIFO empty, fifo_count=0, pending_mask=0;
- starve_cnt=0, alu_stall=0, proto_err=0, ld_ready=0.
REQ-033 A reset asserted mid-operation SHALL discard all buffered loads with no write issued.
REQ-034 The first accept after reset SHALL occur no earlier than the first rising edge after rst falls.

Verification
REQ-035 ALU write alu_valid=1, alu_dst=5, alu_data=16'h1234 at edge N -> after N+1: WriteReg=1, DstReg=5, DstData=16'h1234; after N+2 (alu_valid=0): WriteReg=0.
REQ-036 Load write ld_valid=1, ld_dst=7, ld_data=16'hBEEF at N, no ALU activity -> fifo_count=1 and pending_mask=16'h0080 after N+1; WriteReg=1, DstReg=7 after N+2; pending_mask=0.
REQ-037 Starvation 1 load buffered, alu_valid=1 every cycle -> alu_stall rises after 3 ALU wins; driving alu_valid=0 -> load pops next cycle and alu_stall falls.
REQ-038 Full FIFO and violation 4 loads pushed back-to-back with the ALU busy -> ld_ready=0, alu_stall=1, fifo_count=4; alu_valid=1 then -> ALU write occurs and proto_err=1 sticky.
REQ-039 Register 0 alu_dst=0, then a load with ld_dst=0 -> WriteReg stays 0 throughout; the load still drains and fifo_count returns to 0; pending_mask bit 0 never set.
REQ-040 Async reset rst pulsed between edges with 3 entries buffered -> fifo_count=0 and WriteReg=0 immediately; no buffered entry is ever written afterwards.
